// File: rtl/srl_tap_aligner.sv
// Tap-search controller for a variable-tap SRL delay line: sweeps sel upward until the
// delayed word tracks the reference stream for LOCK_CNT beats. Optional macro TAP_TRACK_EN.
module srl_tap_aligner #(
    parameter int N          = 32,
    parameter int W          = 8,
    parameter int SETTLE_CYC = 2,
    parameter int LOCK_CNT   = 16,
    parameter int LOSS_CNT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 valid_in,
    input  logic [W-1:0]         dly_dout,
    input  logic [W-1:0]         ref_din,
    output logic [$clog2(N)-1:0] sel,
    output logic                 busy,
    output logic                 locked,
    output logic                 fail
);

    localparam int SEL_W = $clog2(N);
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int GD_W  = $clog2(LOCK_CNT + 1);

    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N - 1);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
    localparam logic [GD_W-1:0]  GOOD_LAST   = GD_W'(LOCK_CNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [ST_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic [GD_W-1:0]   good_cnt, good_cnt_nxt;
    logic              match;

    assign match = (dly_dout == ref_din);

`ifdef TAP_TRACK_EN
    localparam int LS_W = $clog2(LOSS_CNT + 1);
    localparam logic [LS_W-1:0] LOSS_LAST = LS_W'(LOSS_CNT - 1);
    logic [LS_W-1:0] loss_cnt, loss_cnt_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= '0;
            settle_cnt <= '0;
            good_cnt   <= '0;
`ifdef TAP_TRACK_EN
            loss_cnt   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            settle_cnt <= settle_cnt_nxt;
            good_cnt   <= good_cnt_nxt;
`ifdef TAP_TRACK_EN
            loss_cnt   <= loss_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        settle_cnt_nxt = settle_cnt;
        good_cnt_nxt   = good_cnt;
`ifdef TAP_TRACK_EN
        loss_cnt_nxt   = loss_cnt;
`endif
        case (state)
            ST_SETTLE: begin
                // Settle beats let the SRL output reflect the newly selected tap.
                if (valid_in) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt_nxt = '0;
                        state_nxt      = ST_CHECK;
                    end else begin
                        settle_cnt_nxt = settle_cnt + ST_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (valid_in && match) begin
                    if (good_cnt == GOOD_LAST) begin
                        good_cnt_nxt = '0;
                        state_nxt    = ST_LOCKED;
                    end else begin
                        good_cnt_nxt = good_cnt + GD_W'(1);
                    end
                end else if (valid_in) begin
                    good_cnt_nxt = '0;
                    if (sel == SEL_LAST) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        sel_nxt   = sel + SEL_W'(1);
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt      = ST_SETTLE;
                    sel_nxt        = '0;
                    settle_cnt_nxt = '0;
                    good_cnt_nxt   = '0;
`ifdef TAP_TRACK_EN
                    loss_cnt_nxt   = '0;
                end else if (state == ST_LOCKED && valid_in) begin
                    // A run of valid mismatches means the line drifted; rescan from tap 0.
                    if (match) begin
                        loss_cnt_nxt = '0;
                    end else if (loss_cnt == LOSS_LAST) begin
                        loss_cnt_nxt   = '0;
                        state_nxt      = ST_SETTLE;
                        sel_nxt        = '0;
                        settle_cnt_nxt = '0;
                        good_cnt_nxt   = '0;
                    end else begin
                        loss_cnt_nxt = loss_cnt + LS_W'(1);
                    end
`endif
                end
            end
        endcase
    end

    assign busy   = (state == ST_SETTLE) || (state == ST_CHECK);
    assign locked = (state == ST_LOCKED);
    assign fail   = (state == ST_FAIL);

endmodule

// File: tb/tb_srl_tap_aligner.sv
// Bench for srl_tap_aligner: SRL/reference stream model, beat-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_srl_tap_aligner;

    localparam int N          = 32;
    localparam int W          = 8;
    localparam int SETTLE_CYC = 2;
    localparam int LOCK_CNT   = 16;
    localparam int LOSS_CNT   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic                 valid_in = 1'b0;
    logic [W-1:0]         dly_dout;
    logic [W-1:0]         ref_din;
    logic [$clog2(N)-1:0] sel;
    logic                 busy, locked, fail;

    int compared = 0;
    int mismatched = 0;
    int beat = 1000;
    int ref_delay = 6;
    int sel_trace [0:255];

    srl_tap_aligner #(
        .N(N), .W(W), .SETTLE_CYC(SETTLE_CYC), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
        .dly_dout(dly_dout), .ref_din(ref_din),
        .sel(sel), .busy(busy), .locked(locked), .fail(fail)
    );

    always #5 clk = ~clk;

    // Word stream indexed by beat number; 37 is odd, so words differing in delay by
    // fewer than 256 beats never collide and only the true tap can match.
    function automatic logic [W-1:0] word(input int x);
        return W'(x * 37 + 11);
    endfunction

    // SRL: tap k presents the word written k+1 valid beats ago.
    assign dly_dout = word(beat - 1 - int'(sel));
    assign ref_din  = word(beat - ref_delay);

    always @(posedge clk) begin
        if (valid_in) beat <= beat + 1;
    end

    // Behavioural model: 0 idle, 1 scanning, 2 locked, 3 failed.
    int m_mode, m_sel, m_seen, m_run, m_miss;
    wire m_hit = (word(beat - 1 - m_sel) == word(beat - ref_delay));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_sel <= 0; m_seen <= 0; m_run <= 0; m_miss <= 0;
        end else if (start && m_mode != 1) begin
            m_mode <= 1; m_sel <= 0; m_seen <= 0; m_run <= 0; m_miss <= 0;
        end else if (valid_in && m_mode == 1) begin
            if (m_seen < SETTLE_CYC) begin
                m_seen <= m_seen + 1;
            end else if (m_hit) begin
                m_run <= m_run + 1;
                if (m_run + 1 == LOCK_CNT) m_mode <= 2;
            end else begin
                m_run <= 0;
                if (m_sel == N - 1) m_mode <= 3;
                else begin
                    m_sel  <= m_sel + 1;
                    m_seen <= 0;
                end
            end
        end else if (valid_in && m_mode == 2) begin
`ifdef TAP_TRACK_EN
            if (m_hit) m_miss <= 0;
            else if (m_miss + 1 == LOSS_CNT) begin
                m_mode <= 1; m_sel <= 0; m_seen <= 0; m_run <= 0; m_miss <= 0;
            end else m_miss <= m_miss + 1;
`endif
        end
    end

    initial forever begin
        @(negedge clk);
        compared++;
        if (int'(sel) != m_sel || busy != (m_mode == 1) || locked != (m_mode == 2)
            || fail != (m_mode == 3)) begin
            mismatched++;
            $display("FAIL model @%0t: sel=%0d busy=%0b locked=%0b fail=%0b, model sel=%0d mode=%0d",
                     $time, sel, busy, locked, fail, m_sel, m_mode);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Runs until the chosen condition (0 locked, 1 fail, 2 not locked) or budget.
    task automatic scan(input bit do_start, input bit gapped, input int what,
                        input int poke, input int budget, output int n);
        bit done, poked;
        n = 0; done = 1'b0; poked = 1'b0;
        start = do_start;
        while (!done && n < budget) begin
            valid_in = gapped ? ((n + 1) % 2 == 0) : 1'b1;
            tick();
            start = 1'b0;
            n++;
            if (n < 256) sel_trace[n] = int'(sel);
            if (poke >= 0 && !poked && int'(sel) == poke) begin
                start = 1'b1;
                poked = 1'b1;
            end
            case (what)
                0:       done = locked;
                1:       done = fail;
                default: done = !locked;
            endcase
        end
        check("wait_done", int'(done), 1);
        valid_in = 1'b1;
    endtask

    initial begin
        int n, bad;
        #1 rst_n = 1'b0;
        repeat (5) begin
            start = 1'($urandom); valid_in = 1'($urandom);
            tick();
        end
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fail", int'(fail), 0);
        start = 1'b0; valid_in = 1'b0;
        rst_n = 1'b1;
        tick();

        // Reset while checking tap 1.
        ref_delay = 6; valid_in = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        repeat (5) tick();
        check("pre_rst_sel", int'(sel), 1);
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_sel", int'(sel), 0);
        check("midrst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Lock at tap 5, continuous valid.
        ref_delay = 6;
        scan(1'b1, 1'b0, 0, -1, 200, n);
        check("lock_cycles", n, 34);
        check("lock_sel", int'(sel), 5);
        check("lock_fail", int'(fail), 0);
        bad = 0;
        for (int k = 1; k <= 34; k++) begin
            int e;
            e = (k - 1) / 3;
            if (e > 5) e = 5;
            if (sel_trace[k] != e) bad++;
        end
        check("sel_step_trace_errors", bad, 0);

        // No match anywhere.
        do_reset();
        ref_delay = 40;
        scan(1'b1, 1'b0, 1, -1, 300, n);
        check("fail_cycles", n, 97);
        check("fail_sel", int'(sel), 31);
        check("fail_busy", int'(busy), 0);
        check("fail_locked", int'(locked), 0);
        start = 1'b1;
        tick(); start = 1'b0;
        check("restart_sel", int'(sel), 0);
        check("restart_busy", int'(busy), 1);
        check("restart_fail", int'(fail), 0);

        // Gapped valid.
        do_reset();
        ref_delay = 6;
        scan(1'b1, 1'b1, 0, -1, 300, n);
        check("gap_cycles", n, 66);
        check("gap_sel", int'(sel), 5);

        // start while busy, then start in LOCKED.
        do_reset();
        scan(1'b1, 1'b0, 0, 3, 200, n);
        check("busy_start_cycles", n, 34);
        check("busy_start_sel", int'(sel), 5);
        start = 1'b1;
        tick(); start = 1'b0;
        check("relock_drop_locked", int'(locked), 0);
        check("relock_drop_sel", int'(sel), 0);
        check("relock_drop_busy", int'(busy), 1);
        scan(1'b0, 1'b0, 0, -1, 200, n);
        check("relock_cycles", n, 33);
        check("relock_sel", int'(sel), 5);

        // Reference delay changes while locked.
        ref_delay = 9;
`ifdef TAP_TRACK_EN
        scan(1'b0, 1'b0, 2, -1, 20, n);
        check("loss_cycles", n, LOSS_CNT);
        check("loss_sel", int'(sel), 0);
        check("loss_busy", int'(busy), 1);
        scan(1'b0, 1'b0, 0, -1, 200, n);
        check("track_sel", int'(sel), 8);
        check("track_locked", int'(locked), 1);
`else
        repeat (40) tick();
        check("hold_locked", int'(locked), 1);
        check("hold_sel", int'(sel), 5);
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
